scoreboard_regfile: RTL
=======================

SCOREBOARD_REGFILE -- requirements
Module: scoreboard_regfile

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the register data width.
REQ-002 Parameter ADDR_W, default 5, SHALL set the address width; depth SHALL be 2**ADDR_W registers.
REQ-003 Parameter ZERO_REG, default 1, SHALL, when 1, make register 0 read as zero, never busy, and ignore writes and reservations to it.
REQ-004 Parameter BYPASS, default 1, SHALL, when 1, enable same-cycle write-to-read forwarding.
REQ-005 Port clk, input, 1, SHALL be the single clock; all state SHALL update on its rising edge.
REQ-006 Port reset, input, 1, SHALL be a synchronous, active-high reset.
REQ-007 Ports rsrc1, rsrc2, input, ADDR_W, SHALL be the read addresses.
REQ-008 Port read, input, 1, SHALL be the read request.
REQ-009 Ports out1, out2, output, DATA_W, SHALL be the registered read data.
REQ-010 Port out_valid, output, 1, SHALL flag that out1/out2/busy1/busy2 hold a new read result.
REQ-011 Ports busy1, busy2, output, 1, SHALL be the registered busy state of rsrc1/rsrc2 at sample time.
REQ-012 Ports write, input, 1; rdst, input, ADDR_W; in, input, DATA_W, SHALL be the write port.
REQ-013 Ports rsv, input, 1; rsv_addr, input, ADDR_W, SHALL reserve a destination (mark it busy).
REQ-014 Port busy_count, output, ADDR_W+1, SHALL give the number of busy registers.
REQ-015 Port wr_err, output, 1, SHALL be a sticky flag for a write to a non-busy register.

Function
REQ-016 A write SHALL update REGISTER[rdst] with in at the rising edge when write=1, except rdst=0 with ZERO_REG=1.
REQ-017 A read with read=1 SHALL register out1/out2 at the rising edge, giving 1-cycle latency, and SHALL set out_valid=1 for that following cycle.
REQ-018 When read=0, out1/out2/busy1/busy2 SHALL hold their values, and out_valid SHALL be 0.
REQ-019 With BYPASS=1, a read of rsrcN equal to rdst in the same cycle as a valid write SHALL return in, and busyN SHALL return 0 unless rsv to that address also occurs that cycle.
REQ-020 With BYPASS=0, the same case SHALL return the pre-write value and pre-write busy bit.
REQ-021 Reading address 0 with ZERO_REG=1 SHALL return 0 and busy 0.
REQ-022 rsv=1 SHALL set busy[rsv_addr] at the edge.
REQ-023 A valid write SHALL clear busy[rdst] at the edge.
REQ-024 When rsv and write target the same address in one cycle, the write SHALL occur and busy SHALL end set (reservation wins).
REQ-025 When rsv targets an already-busy register, busy SHALL remain 1 and busy_count SHALL not change.
REQ-026 busy_count SHALL be registered and SHALL equal the popcount of busy bits after each edge.
REQ-027 busy_count SHALL change by -1, 0 or +1 per cycle and SHALL reach 2**ADDR_W-1 (ZERO_REG=1) or 2**ADDR_W (ZERO_REG=0) without wrap.
REQ-028 A valid write to a register whose busy bit is 0 SHALL still complete and SHALL set wr_err=1 until reset.
REQ-029 A write to register 0 with ZERO_REG=1 SHALL be ignored and SHALL NOT set wr_err.

Reset
REQ-030 While reset=1 at an edge, all registers, busy bits, out1, out2, busy1, busy2, out_valid, busy_count and wr_err SHALL become 0.
REQ-031 reset SHALL take priority over simultaneous read, write and rsv; none of them SHALL take effect in that cycle.
REQ-032 After reset is released, the first edge SHALL accept operations normally, with no extra latency.

Verification
REQ-033 Reset, then rsv=1 with rsv_addr=3 -> busy_count=1; next cycle read rsrc1=3 -> busy1=1, out1=0, out_valid=1.
REQ-034 write=1, rdst=3, in=40, and in the same cycle read, rsrc1=3 (BYPASS=1) -> next cycle out1=40, busy1=0, busy_count=0, wr_err=0.
REQ-035 Same stimulus as REQ-034 with BYPASS=0 -> out1=0 (old value); a read one cycle later -> out1=40.
REQ-036 write=1, rdst=0, in=8'hFF, then read rsrc2=0 (ZERO_REG=1) -> out2=0, busy2=0, wr_err=0.
REQ-037 Write rdst=5, in=10 with register 5 not busy -> register 5 reads 10 and wr_err=1; wr_err holds until reset=1, then 0.
REQ-038 Reserve registers 1..31 on consecutive cycles -> busy_count=31; assert reset while write=1, rdst=1 -> all outputs 0, and register 1 reads 0.

Source files
------------

// File: rtl/scoreboard_regfile_if.sv
// Bus bundle for the scoreboarded register file: read, write and
// reservation requests from the issuing side, read results and status back.
interface scoreboard_regfile_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] rsrc1;
  logic [ADDR_W-1:0] rsrc2;
  logic              read;
  logic [DATA_W-1:0] out1;
  logic [DATA_W-1:0] out2;
  logic              out_valid;
  logic              busy1;
  logic              busy2;
  logic              write;
  logic [ADDR_W-1:0] rdst;
  logic [DATA_W-1:0] in;
  logic              rsv;
  logic [ADDR_W-1:0] rsv_addr;
  logic [ADDR_W:0]   busy_count;
  logic              wr_err;

  modport master (
    output rsrc1, rsrc2, read, write, rdst, in, rsv, rsv_addr,
    input  out1, out2, out_valid, busy1, busy2, busy_count, wr_err
  );

  modport slave (
    input  rsrc1, rsrc2, read, write, rdst, in, rsv, rsv_addr,
    output out1, out2, out_valid, busy1, busy2, busy_count, wr_err
  );
endinterface

// File: rtl/scoreboard_regfile.sv
// Register file with a per-register busy scoreboard. Two registered read
// ports, one write port, one reservation port, a running busy count and a
// sticky error flag for writes that land on a register nobody reserved.
module scoreboard_regfile #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input logic                 clk,
  input logic                 reset,
  scoreboard_regfile_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_reg [DEPTH];
  logic [DEPTH-1:0]  busy_reg;
  logic [DEPTH-1:0]  busy_next;
  logic [ADDR_W:0]   busy_count_reg;
  logic [ADDR_W:0]   busy_count_next;
  logic              wr_err_reg;
  logic              out_valid_reg;
  logic [DATA_W-1:0] rd_data_reg [2];
  logic [1:0]        rd_busy_reg;

  logic              wr_ok;
  logic              rsv_ok;
  logic              cnt_inc;
  logic              cnt_dec;
  logic [ADDR_W-1:0] raddr [2];
  logic [DATA_W-1:0] rd_data_next [2];
  logic [1:0]        rd_busy_next;
  logic [1:0]        fwd_hit;
  logic [1:0]        zero_hit;

  // Register 0 is hard-wired when ZERO_REG is set: writes and reservations
  // to it are dropped before they reach any state.
  assign wr_ok  = bus.write && !(ZERO_REG && (bus.rdst == '0));
  assign rsv_ok = bus.rsv && !(ZERO_REG && (bus.rsv_addr == '0));

  // Count moves by at most one: a reservation of a free register adds one,
  // a write that frees a busy register subtracts one unless the same-cycle
  // reservation re-marks that register.
  assign cnt_inc = rsv_ok && !busy_reg[bus.rsv_addr];
  assign cnt_dec = wr_ok && busy_reg[bus.rdst] &&
                   !(rsv_ok && (bus.rsv_addr == bus.rdst));
  assign busy_count_next = busy_count_reg + (ADDR_W+1)'(cnt_inc)
                                          - (ADDR_W+1)'(cnt_dec);

  // Next busy vector: write clears first, reservation sets last so it wins.
  always_comb begin
    busy_next = busy_reg;
    if (wr_ok) busy_next[bus.rdst] = 1'b0;
    if (rsv_ok) busy_next[bus.rsv_addr] = 1'b1;
  end

  assign raddr[0] = bus.rsrc1;
  assign raddr[1] = bus.rsrc2;

  // Per read port: zero register first, then write forwarding, then storage.
  for (genvar gi = 0; gi < 2; gi++) begin : g_rd
    assign zero_hit[gi] = ZERO_REG && (raddr[gi] == '0);
    assign fwd_hit[gi]  = BYPASS && wr_ok && (raddr[gi] == bus.rdst);
    assign rd_data_next[gi] = zero_hit[gi] ? '0 :
                              fwd_hit[gi]  ? bus.in :
                                             regs_reg[raddr[gi]];
    assign rd_busy_next[gi] = zero_hit[gi] ? 1'b0 :
                              fwd_hit[gi]  ? (rsv_ok && (bus.rsv_addr == raddr[gi])) :
                                             busy_reg[raddr[gi]];
  end

  // All state: storage, scoreboard, count, error flag and read results.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) regs_reg[i] <= '0;
      busy_reg       <= '0;
      busy_count_reg <= '0;
      wr_err_reg     <= 1'b0;
      out_valid_reg  <= 1'b0;
      rd_data_reg[0] <= '0;
      rd_data_reg[1] <= '0;
      rd_busy_reg    <= '0;
    end else begin
      if (wr_ok) regs_reg[bus.rdst] <= bus.in;
      busy_reg       <= busy_next;
      busy_count_reg <= busy_count_next;
      if (wr_ok && !busy_reg[bus.rdst]) wr_err_reg <= 1'b1;
      out_valid_reg  <= bus.read;
      if (bus.read) begin
        rd_data_reg[0] <= rd_data_next[0];
        rd_data_reg[1] <= rd_data_next[1];
        rd_busy_reg    <= rd_busy_next;
      end
    end
  end

  assign bus.out1       = rd_data_reg[0];
  assign bus.out2       = rd_data_reg[1];
  assign bus.busy1      = rd_busy_reg[0];
  assign bus.busy2      = rd_busy_reg[1];
  assign bus.out_valid  = out_valid_reg;
  assign bus.busy_count = busy_count_reg;
  assign bus.wr_err     = wr_err_reg;
endmodule
